// File: rtl/sr_latch_seq.sv
// Purpose : serialises set/reset/toggle commands onto a bank of SR latches, never s&r together.
// Latency : s/r high cycles 1..PULSE_CYC after accept, done at PULSE_CYC+GAP_CYC+1 (nop/bad idx: 1).
// Backpressure: req_ready high only in IDLE; req_valid while busy is ignored, not queued.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req_valid/ready   command handshake; req_idx selects the latch, req_op 00 nop 01 set 10 reset 11 toggle
//   s, r              per-latch set/reset drives (registered, at most one bit high in total)
//   q                 latch outputs, asynchronous to clk, double-flopped before use
//   done, err         one-cycle completion pulse; err = readback mismatch or out-of-range index
module sr_latch_seq #(
  parameter int N_LATCH   = 4,
  parameter int IDX_W     = 2,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [IDX_W-1:0]   req_idx,
  input  logic [1:0]         req_op,
  output logic [N_LATCH-1:0] s,
  output logic [N_LATCH-1:0] r,
  input  logic [N_LATCH-1:0] q,
  output logic               done,
  output logic               err
);

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
  localparam int IDX_N   = 2 ** IDX_W;
  localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_LATCH);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_TOG = 2'b11;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx_q;
  logic               exp_q;      // expected q after the pulse: 1 after set, 0 after reset
  logic [N_LATCH-1:0] q_meta;
  logic [N_LATCH-1:0] q_sync;

  // Synchronised q widened to the full index space so an out-of-range
  // index can never select a non-existent bit.
  logic [IDX_N-1:0]   q_pad;
  logic               bad_idx;
  logic               set_eff;
  logic [N_LATCH-1:0] sel;

  assign q_pad   = IDX_N'(q_sync);
  assign bad_idx = {1'b0, req_idx} >= N_LIM;
  // Toggle is resolved against the latch state seen at accept time.
  assign set_eff = (req_op == OP_SET) || ((req_op == OP_TOG) && !q_pad[req_idx]);
  assign sel     = N_LATCH'(1) << req_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      exp_q     <= 1'b0;
      q_meta    <= '0;
      q_sync    <= '0;
      s         <= '0;
      r         <= '0;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      q_meta <= q;
      q_sync <= q_meta;

      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            idx_q     <= req_idx;
            if (bad_idx || (req_op == OP_NOP)) begin
              // Nothing to drive: report straight away.
              state <= CHECK;
              done  <= 1'b1;
              err   <= bad_idx;
            end else begin
              state <= PULSE;
              cnt   <= CNT_W'(PULSE_CYC - 1);
              exp_q <= set_eff;
              if (set_eff) s <= sel;
              else         r <= sel;
            end
          end
        end

        PULSE: begin
          if (cnt == '0) begin
            s     <= '0;
            r     <= '0;
            state <= GAP;
            cnt   <= CNT_W'(GAP_CYC - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        GAP: begin
          // GAP_CYC >= 2 lets the new latch value cross both sync flops.
          if (cnt == '0) begin
            state <= CHECK;
            done  <= 1'b1;
            err   <= (q_pad[idx_q] != exp_q);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        CHECK: begin
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_seq.sv
// Bench for sr_latch_seq: a 4-latch unit (defaults) driving a behavioural SR latch bank
// with a stuck-at-0 mask, and a 3-latch unit for the out-of-range index case.
// Table vectors, then mid-pulse reset and back-to-back sequences.
module tb_sr_latch_seq;

  localparam int P   = 4;
  localparam int G   = 2;
  localparam int LAT = P + G + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       a_valid, a_ready, a_done, a_err;
  logic [1:0] a_idx, a_op;
  logic [3:0] a_s, a_r, a_q, a_stuck;
  logic [3:0] a_lat = '0;

  logic       b_valid, b_ready, b_done, b_err;
  logic [1:0] b_idx, b_op;
  logic [2:0] b_s, b_r, b_q;
  logic [2:0] b_lat = '0;

  int checks   = 0;
  int failures = 0;
  logic inv_en = 1'b0;

  always #5 clk = ~clk;

  // Behavioural latch banks: set dominates only because s&r never both high.
  always @(a_s or a_r) begin
    for (int i = 0; i < 4; i++) begin
      if (a_s[i])      a_lat[i] = 1'b1;
      else if (a_r[i]) a_lat[i] = 1'b0;
    end
  end
  always @(b_s or b_r) begin
    for (int i = 0; i < 3; i++) begin
      if (b_s[i])      b_lat[i] = 1'b1;
      else if (b_r[i]) b_lat[i] = 1'b0;
    end
  end
  assign a_q = a_lat & ~a_stuck;
  assign b_q = b_lat;

  sr_latch_seq dut (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_idx(a_idx), .req_op(a_op), .s(a_s), .r(a_r), .q(a_q),
    .done(a_done), .err(a_err)
  );

  sr_latch_seq #(.N_LATCH(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_idx(b_idx), .req_op(b_op), .s(b_s), .r(b_r), .q(b_q),
    .done(b_done), .err(b_err)
  );

  // s/r exclusivity on both units, every cycle once enabled.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (((a_s & a_r) != 0) || ($countones(a_s | a_r) > 1) ||
          ((b_s & b_r) != 0) || ($countones(b_s | b_r) > 1)) begin
        failures++;
        $display("FAIL sr_exclusive: a_s=%b a_r=%b b_s=%b b_r=%b required at most one bit high",
                 a_s, a_r, b_s, b_r);
      end
    end
  end

  typedef struct {
    logic       unit;     // 0: 4-latch unit, 1: 3-latch unit
    logic [1:0] op;
    logic [1:0] idx;
    logic [3:0] stuck;
    logic [3:0] exp_s;
    logic [3:0] exp_r;
    logic       exp_err;
    int         lat;      // cycle of done after accept
  } vec_t;

  vec_t tbl[11];

  // Expects to be called at a negedge with the target unit idle.
  task automatic run_vec(input vec_t v, input int n);
    logic [3:0] os, orr, es, er;
    logic od, oe, ordy, ed, ee, erdy;
    a_stuck = v.stuck;
    ordy = v.unit ? b_ready : a_ready;
    checks++;
    if (ordy !== 1'b1) begin
      failures++;
      $display("FAIL vec%0d_ready_pre: got %b want 1", n, ordy);
    end
    if (v.unit) begin b_valid = 1'b1; b_op = v.op; b_idx = v.idx; end
    else        begin a_valid = 1'b1; a_op = v.op; a_idx = v.idx; end
    @(posedge clk);
    for (int k = 1; k <= v.lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Drop valid and scramble the request to show it was captured.
        if (v.unit) begin b_valid = 1'b0; b_op = ~v.op; b_idx = ~v.idx; end
        else        begin a_valid = 1'b0; a_op = ~v.op; a_idx = ~v.idx; end
      end
      if (v.unit) begin
        os = {1'b0, b_s}; orr = {1'b0, b_r}; od = b_done; oe = b_err; ordy = b_ready;
      end else begin
        os = a_s; orr = a_r; od = a_done; oe = a_err; ordy = a_ready;
      end
      es   = (k <= P && v.lat == LAT) ? v.exp_s : 4'b0;
      er   = (k <= P && v.lat == LAT) ? v.exp_r : 4'b0;
      ed   = (k == v.lat);
      ee   = ed & v.exp_err;
      erdy = (k > v.lat);
      checks++;
      if ({os, orr, od, oe, ordy} !== {es, er, ed, ee, erdy}) begin
        failures++;
        $display("FAIL vec%0d_cycle%0d: got s=%b r=%b done=%b err=%b ready=%b want s=%b r=%b done=%b err=%b ready=%b",
                 n, k, os, orr, od, oe, ordy, es, er, ed, ee, erdy);
      end
    end
    a_stuck = '0;
  endtask

  initial begin
    int lowcnt, ndone;
    a_valid = 0; a_idx = 0; a_op = 0; a_stuck = '0;
    b_valid = 0; b_idx = 0; b_op = 0;

    //            unit op     idx    stuck    exp_s    exp_r    err lat
    tbl[0]  = '{1'b0, 2'b01, 2'd2, 4'b0000, 4'b0100, 4'b0000, 1'b0, LAT}; // set 2
    tbl[1]  = '{1'b0, 2'b10, 2'd2, 4'b0000, 4'b0000, 4'b0100, 1'b0, LAT}; // reset 2
    tbl[2]  = '{1'b0, 2'b11, 2'd2, 4'b0000, 4'b0100, 4'b0000, 1'b0, LAT}; // toggle 2 (q=0 -> set)
    tbl[3]  = '{1'b0, 2'b11, 2'd0, 4'b0000, 4'b0001, 4'b0000, 1'b0, LAT}; // toggle 0 (q=0 -> set)
    tbl[4]  = '{1'b0, 2'b11, 2'd0, 4'b0000, 4'b0000, 4'b0001, 1'b0, LAT}; // toggle 0 (q=1 -> reset)
    tbl[5]  = '{1'b0, 2'b01, 2'd1, 4'b0010, 4'b0010, 4'b0000, 1'b1, LAT}; // set 1, stuck at 0
    tbl[6]  = '{1'b0, 2'b00, 2'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1};   // nop
    tbl[7]  = '{1'b0, 2'b10, 2'd3, 4'b0000, 4'b0000, 4'b1000, 1'b0, LAT}; // reset 3, top bit
    tbl[8]  = '{1'b1, 2'b00, 2'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1};   // nop, 3-latch unit
    tbl[9]  = '{1'b1, 2'b01, 2'd3, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1};   // bad index 3
    tbl[10] = '{1'b1, 2'b01, 2'd2, 4'b0000, 4'b0100, 4'b0000, 1'b0, LAT}; // set 2, 3-latch unit

    // Reset asserted between clock edges.
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({a_s, a_r, a_ready, a_done, a_err, b_s, b_r, b_ready, b_done, b_err} !==
        {4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 3'b0, 3'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: a s=%b r=%b rdy=%b done=%b err=%b b s=%b r=%b rdy=%b done=%b err=%b want zeros with ready=1",
               a_s, a_r, a_ready, a_done, a_err, b_s, b_r, b_ready, b_done, b_err);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    inv_en = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

    // Reset in the middle of a pulse: s drops without a clock edge, no done follows.
    a_valid = 1'b1; a_op = 2'b01; a_idx = 2'd3;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_s !== 4'b1000) begin
      failures++;
      $display("FAIL midrst_pulse: got s=%b want 1000", a_s);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_s, a_r, a_ready, a_done, a_err} !== {4'b0, 4'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_async: got s=%b r=%b ready=%b done=%b err=%b want 0 0 1 0 0",
               a_s, a_r, a_ready, a_done, a_err);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (a_done) ndone++;
    end
    checks++;
    if (ndone != 0 || a_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_nodone: got done_pulses=%0d ready=%b want 0 and 1", ndone, a_ready);
    end

    // Back-to-back: valid held high, random non-nop ops.
    a_valid = 1'b1;
    a_op  = 2'($urandom_range(1, 3));
    a_idx = 2'($urandom_range(0, 3));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      lowcnt = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (k == 0) begin
          a_op  = 2'($urandom_range(1, 3));
          a_idx = 2'($urandom_range(0, 3));
        end
        if (a_ready) break;
        lowcnt++;
      end
      checks++;
      if (lowcnt != LAT) begin
        failures++;
        $display("FAIL b2b_cmd%0d_busy: got %0d cycles ready low want %0d", c, lowcnt, LAT);
      end
    end
    a_valid = 1'b0;
    @(negedge clk);
    inv_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
